bank_port_arbiter: RTL and testbench

Parametrised N-port arbiter in front of one BRAM bank owning the inclusive address window [LOWER_ADDR, UPPER_ADDR]. It supersedes the fixed two-port scheduler:
- any port count;
- round-robin fairness instead of fixed priority;
- registered request/grant handshake;
- per-port read-data return tagged through a latency pipeline;
- out-of-range detection.

It sits between the compute (M) modules and one memory bank. One instance is used per bank.

---
 rtl/bank_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_bank_port_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_port_arbiter.sv
// ---------------------------------------------------------------------------
// bank_port_arbiter
//
// Round-robin arbiter that lets NUM_PORTS compute-side requesters share one
// BRAM bank. The bank owns the inclusive address window
// [LOWER_ADDR, UPPER_ADDR]. Requests outside the window are flagged on oor
// and never granted. Read data comes back on a broadcast rdata bus, and a
// one-hot rvalid tags the port that owns each return.
//
// Optional feature macro: ARB_STATS_EN
//   defined   -> conflict_count is a saturating count of contended cycles
//   undefined -> no counter is built; conflict_count is tied to 0
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   req[N]         per-port request, held until granted
//   we[N]          per-port write enable (1 = write, 0 = read)
//   addr[N*AW]     port i address at [i*AW +: AW]
//   wdata[N*DW]    port i write data at [i*DW +: DW]
//   gnt[N]         registered one-hot grant, one-cycle pulse
//   rvalid[N]      one-hot read-return strobe
//   rdata[DW]      read data, broadcast, qualified by rvalid
//   oor[N]         registered out-of-window request flag
//   conflict       registered: two or more eligible requesters last cycle
//   conflict_count saturating contended-cycle count (ARB_STATS_EN)
//   mem_en/mem_we  BRAM enable / write enable
//   mem_addr       BRAM address
//   mem_wdata      BRAM write data
//   mem_rdata      BRAM read data (RD_LATENCY cycles after mem_en)
//
// Handshake: req is the valid side of a valid/ready pair, and gnt is the
// one-cycle ready/accept pulse. A transfer happens on the cycle in which gnt
// is high. req, we, addr and wdata stay stable from req assertion through
// the gnt cycle. The requester may drop req before gnt to withdraw. A port
// that is granted is masked for the next cycle, so it has one cycle to drop
// req after it sees gnt.
// ---------------------------------------------------------------------------
module bank_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LOWER_ADDR = 0,
  parameter int UPPER_ADDR = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [NUM_PORTS-1:0]             oor,
  output logic                             conflict,
  output logic [31:0]                      conflict_count,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int PTR_W = $clog2(NUM_PORTS);
  localparam logic [ADDR_WIDTH-1:0] LO_ADDR = ADDR_WIDTH'(LOWER_ADDR);
  localparam logic [ADDR_WIDTH-1:0] HI_ADDR = ADDR_WIDTH'(UPPER_ADDR);

  logic [ADDR_WIDTH-1:0] portAddr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] portWdata [NUM_PORTS];
  logic [ADDR_WIDTH:0]   loDiff    [NUM_PORTS];
  logic [ADDR_WIDTH:0]   hiDiff    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  inRange;
  logic [NUM_PORTS-1:0]  eligible;
  logic                  conflictNext;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      nextPtr;
  logic [PTR_W-1:0]      winIdx;
  logic [PTR_W-1:0]      candIdx;
  logic                  winFound;
  int                    cand;

  // Port index of the access currently on mem_*; it travels with reads.
  logic [PTR_W-1:0]      issueIdx;
  logic [RD_LATENCY-1:0] pipeValid;
  logic [PTR_W-1:0]      pipeIdx [RD_LATENCY];

  // Window test. Each bound is checked as the borrow out of a one-bit-wider
  // subtraction. This keeps the test well formed when a bound is 0 or the
  // top of the address space.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      portAddr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      portWdata[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      loDiff[i]    = {1'b0, portAddr[i]} - {1'b0, LO_ADDR};
      hiDiff[i]    = {1'b0, HI_ADDR} - {1'b0, portAddr[i]};
      inRange[i]   = ((loDiff[i] >> ADDR_WIDTH) == '0) &&
                     ((hiDiff[i] >> ADDR_WIDTH) == '0);
    end
  end

  assign eligible     = req & inRange & ~gnt;
  assign conflictNext = ($countones(eligible) >= 2);

  // Rotating search: start at ptr, wrap at NUM_PORTS-1, first eligible wins.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = 0;
    candIdx  = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      cand    = (int'(ptr) + off) % NUM_PORTS;
      candIdx = PTR_W'(cand);
      if (!winFound && eligible[candIdx]) begin
        winFound = 1'b1;
        winIdx   = candIdx;
      end
    end
  end

  assign nextPtr = PTR_W'((int'(winIdx) + 1) % NUM_PORTS);

  // Issue stage, pointer, status flags and read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      issueIdx  <= '0;
      ptr       <= '0;
      oor       <= '0;
      conflict  <= 1'b0;
      pipeValid <= '0;
      for (int s = 0; s < RD_LATENCY; s++) pipeIdx[s] <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      gnt    <= winFound ? (NUM_PORTS'(1) << winIdx) : '0;
      mem_en <= winFound;
      mem_we <= winFound & we[winIdx];
      if (winFound) begin
        mem_addr  <= portAddr[winIdx];
        mem_wdata <= portWdata[winIdx];
        issueIdx  <= winIdx;
        ptr       <= nextPtr;
      end
      oor      <= req & ~inRange;
      conflict <= conflictNext;

      // The read tag enters when the read sits on mem_*. It leaves
      // RD_LATENCY cycles later, together with the BRAM data.
      for (int s = RD_LATENCY - 1; s > 0; s--) begin
        pipeValid[s] <= pipeValid[s-1];
        pipeIdx[s]   <= pipeIdx[s-1];
      end
      pipeValid[0] <= mem_en & ~mem_we;
      pipeIdx[0]   <= issueIdx;

      rvalid <= pipeValid[RD_LATENCY-1] ?
                (NUM_PORTS'(1) << pipeIdx[RD_LATENCY-1]) : '0;
      if (pipeValid[RD_LATENCY-1]) rdata <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] statCount;

  // This counts in step with the registered conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      statCount <= '0;
    end else if (conflictNext && (statCount != 32'hFFFF_FFFF)) begin
      statCount <= statCount + 32'd1;
    end
  end

  assign conflict_count = statCount;
`else
  assign conflict_count = 32'd0;
`endif

endmodule

// File: tb/tb_bank_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_port_arbiter
//
// Bench for bank_port_arbiter with the default parameters: 4 ports, window
// [0,4] and read latency 1. It has four parts:
//   - a table of single-grant vectors, each applied from a fresh reset;
//   - hand-written sequences for read return, round-robin order, mixed
//     write-then-read, reset during a read, and the conflict statistics;
//   - a randomized run checked against a transaction-level reference model;
//   - one summary line at the end.
// A behavioural BRAM model with 1-cycle read latency drives mem_rdata.
// ---------------------------------------------------------------------------
module tb_bank_port_arbiter;

  localparam int NP    = 4;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int LOWER = 0;
  localparam int UPPER = 4;
  localparam int LAT   = 1;

  // ---------------- clock / reset ----------------
  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     req;
  logic [NP-1:0]     we;
  logic [NP*AW-1:0]  addrBus;
  logic [NP*DW-1:0]  wdataBus;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic [NP-1:0]     oor;
  logic              conflict;
  logic [31:0]       conflictCount;
  logic              memEn;
  logic              memWe;
  logic [AW-1:0]     memAddr;
  logic [DW-1:0]     memWdata;
  logic [DW-1:0]     memRdata;

  bank_port_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LOWER_ADDR(LOWER),
    .UPPER_ADDR(UPPER),
    .RD_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .we            (we),
    .addr          (addrBus),
    .wdata         (wdataBus),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .oor           (oor),
    .conflict      (conflict),
    .conflict_count(conflictCount),
    .mem_en        (memEn),
    .mem_we        (memWe),
    .mem_addr      (memAddr),
    .mem_wdata     (memWdata),
    .mem_rdata     (memRdata)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] initWord(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [NP*AW-1:0] pack4(input int a0, input int a1,
                                             input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // ---------------- BRAM model (1-cycle read latency) ----------------
  logic [DW-1:0] bramMem [32];
  bit            bramInit = 1'b0;

  always @(posedge clk) begin
    if (!bramInit) begin
      for (int i = 0; i < 32; i++) bramMem[i] <= initWord(i);
      memRdata <= '0;
      bramInit <= 1'b1;
    end else if (memEn) begin
      if (memWe) bramMem[memAddr[4:0]] <= memWdata;
      else       memRdata <= bramMem[memAddr[4:0]];
    end
  end

  // ---------------- reference model ----------------
  // This model works per transaction. It picks the eligible port that is
  // closest at or after the pointer. It keeps its own copy of the memory
  // contents. Each read issued goes into a queue with the edge number at
  // which its return is due.
  bit            mInit = 1'b0;
  logic [DW-1:0] refMem [32];
  logic [NP-1:0] mGnt, mOor, mRvalid;
  logic          mEn, mWe, mConf;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mRdata;
  logic [31:0]   mCount;
  int            mPtr;
  int            edgeNo = 0;
  int            dueQ[$];
  int            portQ[$];
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin : refModel
    logic [NP-1:0] elig;
    logic [NP-1:0] oorN;
    int win, bestD, d, nElig, a, p;
    if (!mInit) begin
      for (int i = 0; i < 32; i++) refMem[i] = initWord(i);
      mInit = 1'b1;
    end
    edgeNo++;
    if (rst) begin
      mGnt = '0; mOor = '0; mRvalid = '0; mEn = 1'b0; mWe = 1'b0;
      mConf = 1'b0; mAddr = '0; mWdata = '0; mRdata = '0; mCount = '0;
      mPtr = 0;
      dueQ.delete(); portQ.delete(); exp_q.delete();
    end else begin
      elig = '0; oorN = '0; nElig = 0;
      for (int i = 0; i < NP; i++) begin
        a = int'(addrBus[i*AW +: AW]);
        if (req[i] && (a < LOWER || a > UPPER)) oorN[i] = 1'b1;
        if (req[i] && a >= LOWER && a <= UPPER && !mGnt[i]) begin
          elig[i] = 1'b1;
          nElig++;
        end
      end
      win = -1; bestD = NP;
      for (int j = 0; j < NP; j++) begin
        if (elig[j]) begin
          d = (j - mPtr + NP) % NP;
          if (d < bestD) begin bestD = d; win = j; end
        end
      end
      mRvalid = '0;
      if (dueQ.size() > 0 && dueQ[0] == edgeNo) begin
        void'(dueQ.pop_front());
        p       = portQ.pop_front();
        mRvalid = NP'(1) << p;
        mRdata  = exp_q.pop_front();
      end
      if (win >= 0) begin
        a      = int'(addrBus[win*AW +: AW]);
        mGnt   = NP'(1) << win;
        mEn    = 1'b1;
        mWe    = we[win];
        mAddr  = AW'(a);
        mWdata = wdataBus[win*DW +: DW];
        mPtr   = (win + 1) % NP;
        if (we[win]) begin
          refMem[a % 32] = mWdata;
        end else begin
          dueQ.push_back(edgeNo + LAT + 1);
          portQ.push_back(win);
          exp_q.push_back(refMem[a % 32]);
        end
      end else begin
        mGnt = '0; mEn = 1'b0; mWe = 1'b0;
      end
      mOor  = oorN;
      mConf = (nElig >= 2);
      if (mConf && mCount != 32'hFFFF_FFFF) mCount = mCount + 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    check("rnd gnt", gnt, mGnt);
    check("rnd mem_en", memEn, mEn);
    if (mEn) check("rnd mem_we", memWe, mWe);
    check("rnd mem_addr", memAddr, mAddr);
    check("rnd mem_wdata", memWdata, mWdata);
    check("rnd oor", oor, mOor);
    check("rnd conflict", conflict, mConf);
    check("rnd rvalid", rvalid, mRvalid);
    if (mRvalid != '0) check("rnd rdata", rdata, mRdata);
`ifdef ARB_STATS_EN
    check("rnd conflict_count", conflictCount, mCount);
`else
    check("rnd conflict_count", conflictCount, 32'd0);
`endif
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " gnt"}, gnt, 0);
    check({tag, " rvalid"}, rvalid, 0);
    check({tag, " oor"}, oor, 0);
    check({tag, " conflict"}, conflict, 0);
    check({tag, " mem_en"}, memEn, 0);
    check({tag, " mem_we"}, memWe, 0);
    check({tag, " mem_addr"}, memAddr, 0);
    check({tag, " mem_wdata"}, memWdata, 0);
    check({tag, " rdata"}, rdata, 0);
    check({tag, " conflict_count"}, conflictCount, 0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. Returns at the next negedge with rst released.
  task automatic doReset();
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic driveRandom();
    for (int i = 0; i < NP; i++) begin
      if (req[i] && (gnt[i] || oor[i])) begin
        req[i] = 1'b0;
      end else if (req[i]) begin
        if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req[i]                = 1'b1;
        we[i]                 = 1'($urandom_range(0, 1));
        addrBus[i*AW +: AW]   = AW'($urandom_range(0, 6));
        wdataBus[i*DW +: DW]  = $urandom;
      end
    end
    if (rst) rst = 1'b0;
    else if ($urandom_range(0, 299) == 0) rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addrBus;
    logic [NP-1:0]    gnt;
    logic [NP-1:0]    oor;
    logic             conf;
    logic             en;
    logic             wen;
    logic [AW-1:0]    maddr;
    logic [DW-1:0]    mwd;
  } vec_t;

  vec_t vecs [8];

  // Watchdog: the run must end on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    vecs[0] = '{4'b0100, 4'b0000, pack4(0, 0, 3, 0), 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 13'd3, 32'h3333_3333};
    vecs[1] = '{4'b0011, 4'b0000, pack4(4, 5, 0, 0), 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0, 13'd4, 32'h1111_1111};
    vecs[2] = '{4'b1111, 4'b0000, pack4(1, 1, 1, 1), 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 13'd1, 32'h1111_1111};
    vecs[3] = '{4'b1010, 4'b0000, pack4(0, 0, 0, 2), 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 13'd0, 32'h2222_2222};
    vecs[4] = '{4'b0010, 4'b0000, pack4(0, 5, 0, 0), 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 13'd0, 32'h0000_0000};
    vecs[5] = '{4'b1000, 4'b1000, pack4(0, 0, 0, 4), 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 13'd4, 32'h4444_4444};
    vecs[6] = '{4'b0000, 4'b0000, pack4(0, 0, 0, 0), 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 13'd0, 32'h0000_0000};
    vecs[7] = '{4'b1100, 4'b0000, pack4(0, 0, 7, 0), 4'b1000, 4'b0100, 1'b0, 1'b1, 1'b0, 13'd0, 32'h4444_4444};

    rst      = 1'b1;
    req      = '0;
    we       = '0;
    addrBus  = '0;
    wdataBus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Table: one grant cycle from a fresh reset per vector.
    wdataBus = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int v = 0; v < 8; v++) begin
      doReset();
      req     = vecs[v].req;
      we      = vecs[v].we;
      addrBus = vecs[v].addrBus;
      step();
      check($sformatf("vec%0d gnt", v), gnt, vecs[v].gnt);
      check($sformatf("vec%0d oor", v), oor, vecs[v].oor);
      check($sformatf("vec%0d conflict", v), conflict, vecs[v].conf);
      check($sformatf("vec%0d mem_en", v), memEn, vecs[v].en);
      check($sformatf("vec%0d mem_we", v), memWe, vecs[v].wen);
      check($sformatf("vec%0d mem_addr", v), memAddr, vecs[v].maddr);
      check($sformatf("vec%0d mem_wdata", v), memWdata, vecs[v].mwd);
      check($sformatf("vec%0d rvalid", v), rvalid, 0);
      req = '0;
    end

    // Single read: port 2, address 3. Data returns two cycles after gnt.
    doReset();
    req = 4'b0100; we = '0; addrBus = pack4(0, 0, 3, 0);
    step();
    check("rd gnt", gnt, 4'b0100);
    check("rd mem_addr", memAddr, 3);
    check("rd mem_en", memEn, 1);
    req = '0;
    step();
    check("rd rvalid early", rvalid, 0);
    step();
    check("rd rvalid", rvalid, 4'b0100);
    check("rd rdata", rdata, initWord(3));
    step();
    check("rd rvalid single", rvalid, 0);

    // Round-robin under full contention. Each port drops req for one
    // cycle after its grant. This also gives 10 contended cycles.
    doReset();
    we = '0; addrBus = pack4(0, 1, 2, 3); req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c < 5) check($sformatf("rr gnt%0d", c), gnt, NP'(1) << order[c]);
      check($sformatf("rr conflict%0d", c), conflict, 1);
      req = ~gnt;
    end
`ifdef ARB_STATS_EN
    check("stats conflict_count", conflictCount, 10);
`else
    check("stats conflict_count", conflictCount, 0);
`endif
    req = '0;

    // Mixed: port 0 writes DEADBEEF to address 2, then port 3 reads it back.
    doReset();
    req = 4'b0001; we = 4'b0001; addrBus = pack4(2, 0, 0, 2);
    wdataBus[0 +: DW] = 32'hDEAD_BEEF;
    step();
    check("mix wr gnt", gnt, 4'b0001);
    check("mix wr mem_we", memWe, 1);
    check("mix wr mem_wdata", memWdata, 32'hDEAD_BEEF);
    req = 4'b1000; we = 4'b0000;
    step();
    check("mix rd gnt", gnt, 4'b1000);
    check("mix rd mem_we", memWe, 0);
    check("mix rd mem_addr", memAddr, 2);
    req = '0;
    step();
    check("mix rvalid early", rvalid, 0);
    step();
    check("mix rvalid", rvalid, 4'b1000);
    check("mix rdata", rdata, 32'hDEAD_BEEF);

    // Reset in the cycle after a read grant: the read is discarded.
    doReset();
    req = 4'b0010; we = '0; addrBus = pack4(0, 1, 0, 0);
    step();
    check("rst gnt", gnt, 4'b0010);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    checkAllZero("rst after");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rst no rvalid%0d", c), rvalid, 0);
    end

    // Randomized traffic against the reference model.
    doReset();
    we = '0;
    for (int c = 0; c < 2000; c++) begin
      step();
      compareModel();
      driveRandom();
    end

    req = '0;
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
